// File: rtl/vector_operand_loader.sv
// Stream-to-vector front end: parses LOAD_A / LOAD_B / EXEC frames from a word stream
// into operand vectors, lengths and ALU controls. Optional VLOAD_ZERO_FILL_EN clears the target on LEN.
module vector_operand_loader #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BITS-1:0] A [N-1:0],
  output logic [7:0]      A_len,
  output logic [BITS-1:0] B [N-1:0],
  output logic [7:0]      B_len,
  output logic [BITS-1:0] scalar,
  output logic [2:0]      op_sel,
  output logic            scalar_sel,
  output logic            set,
  output logic            en,
  output logic            overflow,
  output logic            cmd_err
);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DRAIN, S_SCALAR, S_ISSUE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      idx_q, idx_d, len_q, len_d, a_len_q, a_len_d, b_len_q, b_len_d;
  logic            tgt_q, tgt_d, pssel_q, pssel_d, ssel_q, ssel_d;
  logic [2:0]      pop_q, pop_d, op_q, op_d;
  logic [BITS-1:0] scalar_q, scalar_d;
  logic [BITS-1:0] a_q [N-1:0];
  logic [BITS-1:0] a_d [N-1:0];
  logic [BITS-1:0] b_q [N-1:0];
  logic [BITS-1:0] b_d [N-1:0];
  logic            en_q, en_d, ovf_q, ovf_d, err_q, err_d;
  logic            xfer, commit;
  logic [7:0]      cap_len, commit_len;
  logic [8:0]      idx_nxt;

  localparam logic [8:0] NCAP = 9'(N);

  assign xfer    = in_valid & in_ready;
  assign idx_nxt = {1'b0, idx_q} + 9'd1;
  assign cap_len = ({1'b0, len_q} > NCAP) ? 8'(N) : len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      tgt_q    <= 1'b0;
      pop_q    <= '0;
      pssel_q  <= 1'b0;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      a_len_q  <= '0;
      b_len_q  <= '0;
      scalar_q <= '0;
      op_q     <= '0;
      ssel_q   <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      tgt_q    <= tgt_d;
      pop_q    <= pop_d;
      pssel_q  <= pssel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_len_q  <= a_len_d;
      b_len_q  <= b_len_d;
      scalar_q <= scalar_d;
      op_q     <= op_d;
      ssel_q   <= ssel_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer) begin
                  case (in_data[1:0])
                    2'd0, 2'd1: state_d = S_LEN;
                    2'd2:       state_d = S_SCALAR;
                    default:    state_d = S_IDLE;
                  endcase
                end
      S_LEN:    if (xfer) state_d = (in_data[7:0] == 8'd0) ? S_IDLE : S_DATA;
      // Last in-range element either finishes the frame or hands the tail to DRAIN.
      S_DATA:   if (xfer) begin
                  if (idx_nxt == {1'b0, len_q}) state_d = S_IDLE;
                  else if (idx_nxt == NCAP)     state_d = S_DRAIN;
                end
      S_DRAIN:  if (xfer && idx_nxt == {1'b0, len_q}) state_d = S_IDLE;
      S_SCALAR: if (xfer) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;  len_d = len_q;  tgt_d = tgt_q;  pop_d = pop_q;  pssel_d = pssel_q;
    a_d = a_q;  b_d = b_q;  a_len_d = a_len_q;  b_len_d = b_len_q;
    scalar_d = scalar_q;  op_d = op_q;  ssel_d = ssel_q;
    en_d = en_q;  ovf_d = ovf_q;  err_d = err_q;
    commit = 1'b0;  commit_len = '0;
    case (state_q)
      S_IDLE: if (xfer) begin
        tgt_d   = in_data[0];
        pop_d   = in_data[4:2];
        pssel_d = in_data[5];
        if (in_data[1:0] == 2'd3) err_d = 1'b1;
      end
      S_LEN: if (xfer) begin
        len_d = in_data[7:0];
        idx_d = '0;
`ifdef VLOAD_ZERO_FILL_EN
        for (int i = 0; i < N; i++) begin
          if (tgt_q) b_d[i] = '0;
          else       a_d[i] = '0;
        end
`endif
        if (in_data[7:0] == 8'd0) commit = 1'b1;
      end
      S_DATA: if (xfer) begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == 8'(i)) begin
            if (tgt_q) b_d[i] = in_data;
            else       a_d[i] = in_data;
          end
        end
        idx_d      = idx_nxt[7:0];
        commit_len = cap_len;
        if (idx_nxt == {1'b0, len_q}) commit = 1'b1;
        else if (idx_nxt == NCAP)     ovf_d  = 1'b1;
      end
      S_DRAIN: if (xfer) begin
        idx_d      = idx_nxt[7:0];
        commit_len = cap_len;
        if (idx_nxt == {1'b0, len_q}) commit = 1'b1;
      end
      S_SCALAR: if (xfer) begin
        scalar_d = in_data;
        op_d     = pop_q;
        ssel_d   = pssel_q;
      end
      S_ISSUE: en_d = 1'b1;
      default: ;
    endcase
    if (commit) begin
      if (tgt_q) b_len_d = commit_len;
      else       a_len_d = commit_len;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    set      = 1'b0;
    if (!rst) in_ready = (state_q != S_ISSUE);
    if (state_q == S_ISSUE) set = 1'b1;
  end

  assign A          = a_q;
  assign B          = b_q;
  assign A_len      = a_len_q;
  assign B_len      = b_len_q;
  assign scalar     = scalar_q;
  assign op_sel     = op_q;
  assign scalar_sel = ssel_q;
  assign en         = en_q;
  assign overflow   = ovf_q;
  assign cmd_err    = err_q;

endmodule

// File: tb/tb_vector_operand_loader.sv
// Bench for vector_operand_loader: frame table with hand expectations, reset and back-to-back
// EXEC sequences, then random frames checked against a frame-level reference model.
module tb_vector_operand_loader;
  localparam int BITS = 8;
  localparam int N    = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic [BITS-1:0] in_data = '0;
  logic            in_valid = 1'b0, in_ready;
  logic [BITS-1:0] A [N-1:0];
  logic [BITS-1:0] B [N-1:0];
  logic [7:0]      A_len, B_len;
  logic [BITS-1:0] scalar;
  logic [2:0]      op_sel;
  logic            scalar_sel, set, en, overflow, cmd_err;

  always #5 clk = ~clk;

  vector_operand_loader #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .A_len(A_len), .B(B), .B_len(B_len), .scalar(scalar), .op_sel(op_sel),
    .scalar_sel(scalar_sel), .set(set), .en(en), .overflow(overflow), .cmd_err(cmd_err));

  int checks = 0, errors = 0, cyc = 0, set_cnt = 0, exec_cnt = 0;
  int set_cyc[$];
  logic [2:0] set_op[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // in_ready must drop exactly in the execute-pulse cycles
  always @(negedge clk) if (!rst) begin
    chk("rdy_vs_set", {31'b0, in_ready}, {31'b0, ~set});
    if (set) begin
      set_cnt++;
      set_cyc.push_back(cyc);
      set_op.push_back(op_sel);
    end
  end

  // Reference model: whole-frame effects only.
  logic [7:0] m_a [N], m_b [N];
  logic [7:0] m_alen, m_blen, m_sc;
  logic [2:0] m_op;
  logic       m_ssel, m_en, m_ovf, m_err;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_a[i] = 0; m_b[i] = 0; end
    m_alen = 0; m_blen = 0; m_sc = 0; m_op = 0; m_ssel = 0; m_en = 0; m_ovf = 0; m_err = 0;
  endtask

  typedef struct {
    logic [1:0] kind;
    int         len;
    logic [7:0] d [8];
    logic [2:0] op;
    logic       ssel;
    logic [7:0] sc;
    int         gap;
    bit         b2b;
    logic [7:0] e_alen, e_blen;
    logic       e_ovf, e_err;
    logic [2:0] e_op;
  } frame_t;

  function automatic frame_t mk(input logic [1:0] kind, input int len, input logic [63:0] dw,
                                input logic [2:0] op, input logic ssel, input logic [7:0] sc,
                                input int gap, input bit b2b, input logic [7:0] ea, input logic [7:0] eb,
                                input logic eo, input logic ee, input logic [2:0] eop);
    frame_t f;
    f.kind = kind; f.len = len; f.op = op; f.ssel = ssel; f.sc = sc; f.gap = gap; f.b2b = b2b;
    for (int k = 0; k < 8; k++) f.d[k] = dw[8*k +: 8];
    f.e_alen = ea; f.e_blen = eb; f.e_ovf = eo; f.e_err = ee; f.e_op = eop;
    return f;
  endfunction

  task automatic m_load(input frame_t f);
    int c;
    c = (f.len > N) ? N : f.len;
`ifdef VLOAD_ZERO_FILL_EN
    for (int i = 0; i < N; i++) if (f.kind == 0) m_a[i] = 0; else m_b[i] = 0;
`endif
    for (int k = 0; k < c; k++) if (f.kind == 0) m_a[k] = f.d[k]; else m_b[k] = f.d[k];
    if (f.kind == 0) m_alen = 8'(c); else m_blen = 8'(c);
    if (f.len > N) m_ovf = 1;
  endtask

  task automatic send(input logic [7:0] w, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gap)) begin @(negedge clk); in_data = 8'($urandom); end
    end
    @(negedge clk);
    in_data = w; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 16) begin @(negedge clk); t++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_frame(input frame_t f);
    send({2'b00, f.ssel, f.op, f.kind}, f.gap);
    if (f.kind < 2) begin
      send(f.len[7:0], f.gap);
      for (int k = 0; k < f.len; k++) send((k < 8) ? f.d[k] : 8'($urandom), f.gap);
      m_load(f);
    end else if (f.kind == 2) begin
      send(f.sc, f.gap);
      m_sc = f.sc; m_op = f.op; m_ssel = f.ssel; m_en = 1; exec_cnt++;
      @(negedge clk);
      chk("set_after_scalar", {31'b0, set}, 1);
      chk("op_at_set", {29'b0, op_sel}, {29'b0, f.op});
    end else begin
      m_err = 1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_A%0d", tag, i), A[i], m_a[i]);
      chk($sformatf("%s_B%0d", tag, i), B[i], m_b[i]);
    end
    chk({tag, "_alen"}, A_len, m_alen);
    chk({tag, "_blen"}, B_len, m_blen);
    chk({tag, "_scalar"}, scalar, m_sc);
    chk({tag, "_op"}, op_sel, m_op);
    chk({tag, "_ssel"}, scalar_sel, m_ssel);
    chk({tag, "_en"}, en, m_en);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_err"}, cmd_err, m_err);
    chk({tag, "_set"}, set, 0);
  endtask

  frame_t tbl[15];
  frame_t f;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(0, 4, 64'h14_0A_05_00, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    tbl[1] = mk(2, 0, 0, 3, 1, 8'hFF, 0, 0, 4, 0, 0, 0, 3);
    tbl[2] = mk(1, 6, 64'h06_05_04_03_02_01, 0, 0, 0, 0, 0, 4, 4, 1, 0, 3);
    tbl[3] = mk(2, 0, 0, 5, 0, 8'h12, 0, 0, 4, 4, 1, 0, 5);
    tbl[4] = mk(0, 2, 64'h09_07, 0, 0, 0, 0, 0, 2, 4, 1, 0, 5);
    tbl[5] = mk(3, 0, 0, 0, 0, 0, 2, 0, 2, 4, 1, 1, 5);
    tbl[6] = mk(1, 0, 0, 0, 0, 0, 3, 0, 2, 0, 1, 1, 5);
    for (int i = 0; i < 8; i++)
      tbl[7+i] = mk(2, 0, 0, 3'(i), i[0], 8'(i*3+1), 0, 1, 2, 0, 1, 1, 3'(i));

    m_reset();
    #2;
    check_all("rst0");
    chk("rst0_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst0_ready_rel", in_ready, 1);

    for (int i = 0; i < 15; i++) begin
      if (i == 7) begin set_cyc.delete(); set_op.delete(); end
      do_frame(tbl[i]);
      chk($sformatf("t%0d_alen", i), A_len, tbl[i].e_alen);
      chk($sformatf("t%0d_blen", i), B_len, tbl[i].e_blen);
      chk($sformatf("t%0d_ovf", i), overflow, tbl[i].e_ovf);
      chk($sformatf("t%0d_err", i), cmd_err, tbl[i].e_err);
      chk($sformatf("t%0d_op", i), op_sel, tbl[i].e_op);
      if (!tbl[i].b2b) begin idle(); check_all($sformatf("t%0d", i)); end
      if (i == 1) begin
        chk("t1_A3", A[3], 20);
        chk("t1_scalar", scalar, 8'hFF);
        chk("t1_en", en, 1);
      end
      if (i == 4) begin
`ifdef VLOAD_ZERO_FILL_EN
        chk("t4_A2", A[2], 0); chk("t4_A3", A[3], 0);
`else
        chk("t4_A2", A[2], 10); chk("t4_A3", A[3], 20);
`endif
        chk("t4_A1", A[1], 9);
      end
    end
    idle();
    check_all("b2b");
    chk("b2b_count", set_cyc.size(), 8);
    for (int i = 0; i < set_cyc.size(); i++) begin
      chk($sformatf("b2b_op%0d", i), {29'b0, set_op[i]}, i);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), set_cyc[i] - set_cyc[i-1], 3);
    end

    // Reset in the middle of a LOAD_A data phase
    send(8'h00, 0); send(8'd4, 0); send(8'h11, 0); send(8'h22, 0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    m_reset();
    check_all("rstmid");
    chk("rstmid_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rstmid_ready_rel", in_ready, 1);
    do_frame(mk(0, 3, 64'h33_22_11, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0));
    idle();
    check_all("postrst");

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      f = mk((sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3,
             $urandom_range(0, 7), {$urandom, $urandom}, 0, 0, 8'($urandom),
             $urandom_range(0, 2), 0, 0, 0, 0, 0, 0);
      if (f.kind == 2) begin f.op = 3'($urandom); f.ssel = 1'($urandom); end
      do_frame(f);
      idle();
      check_all($sformatf("rnd%0d", r));
    end
    chk("set_total", set_cnt, exec_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
